// File: rtl/valid_bitvector_alloc_pkg.sv
// Shared types and mask helpers for the valid-bitvector slot allocator.
package valid_bitvector_alloc_pkg;

  localparam int unsigned MAX_ENTRIES       = 1024;
  localparam int unsigned DEF_NUM_ENTRIES   = 64;
  localparam int unsigned DEF_NUM_CLR_PORTS = 2;

  typedef logic [MAX_ENTRIES-1:0]               wide_mask_t;
  typedef logic [$clog2(DEF_NUM_ENTRIES)-1:0]   def_index_t;
  typedef logic [$clog2(DEF_NUM_ENTRIES+1)-1:0] def_count_t;

  // Out-of-range indices produce an empty mask so stray tags cannot touch state.
  function automatic wide_mask_t onehot_mask(input int unsigned idx,
                                             input int unsigned num_entries,
                                             input logic        en);
    wide_mask_t m;
    m = '0;
    if (en && (idx < num_entries) && (idx < MAX_ENTRIES)) begin
      m = wide_mask_t'(1) << idx;
    end
    return m;
  endfunction

  function automatic int unsigned popcount(input wide_mask_t v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_ENTRIES; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/valid_bitvector_alloc_lowest_zero_encoder.sv
// Priority encoder: finds the lowest clear bit of an occupancy vector.
module lowest_zero_encoder #(
  parameter int NUM_ENTRIES = 64,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic [NUM_ENTRIES-1:0] occ_i,
  output logic                   any_o,
  output logic [IDX_W-1:0]       index_o
);

  // Scan downward so the last hit, and therefore the result, is the lowest zero.
  always_comb begin
    any_o   = 1'b0;
    index_o = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!occ_i[i]) begin
        any_o   = 1'b1;
        index_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/valid_bitvector_alloc.sv
// Valid-bitvector slot allocator with lowest-free grant, direct set and multi-port clear.
// Optional double-free checker enabled by defining VALID_BITVECTOR_ALLOC_DBL_FREE_CHK_EN.
module valid_bitvector_alloc
  import valid_bitvector_alloc_pkg::*;
#(
  parameter int NUM_ENTRIES   = 64,
  parameter int NUM_CLR_PORTS = 2,
  parameter int ENTRY_W       = $clog2(NUM_ENTRIES),
  parameter int COUNT_W       = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             alloc_req_val,
  output logic                             alloc_req_rdy,
  output logic [ENTRY_W-1:0]               alloc_index,
  input  logic                             set_val,
  input  logic [ENTRY_W-1:0]               set_index,
  input  logic [NUM_CLR_PORTS-1:0]         clr_val,
  input  logic [NUM_CLR_PORTS*ENTRY_W-1:0] clr_index,
  output logic [NUM_ENTRIES-1:0]           valid_bitvector,
  output logic [COUNT_W-1:0]               occupied_count,
  output logic                             full,
  output logic                             empty
`ifdef VALID_BITVECTOR_ALLOC_DBL_FREE_CHK_EN
  ,
  output logic                             dbl_free_err,
  output logic [ENTRY_W-1:0]               dbl_free_index
`endif
);

  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [COUNT_W-1:0]     count_q, count_d;
  logic                   full_q, full_d;
  logic                   empty_q, empty_d;

  logic [NUM_ENTRIES-1:0] set_mask, alloc_mask, clr_mask, occ;
  logic                   any_free;
  logic [ENTRY_W-1:0]     free_idx;
  logic                   grant;

  // Handshake: a grant happens in any cycle where alloc_req_val && alloc_req_rdy;
  // rdy/index never look at val or at clears, so a freed slot is offered one cycle later.
  always_comb begin
    set_mask = NUM_ENTRIES'(onehot_mask(32'(set_index), NUM_ENTRIES, set_val));
    occ      = valid_q | set_mask;
  end

  lowest_zero_encoder #(
    .NUM_ENTRIES(NUM_ENTRIES),
    .IDX_W      (ENTRY_W)
  ) u_enc (
    .occ_i  (occ),
    .any_o  (any_free),
    .index_o(free_idx)
  );

  always_comb begin
    alloc_req_rdy = any_free;
    alloc_index   = free_idx;
    grant         = alloc_req_val & any_free;
    alloc_mask    = NUM_ENTRIES'(onehot_mask(32'(free_idx), NUM_ENTRIES, grant));
  end

  always_comb begin
    clr_mask = '0;
    for (int p = 0; p < NUM_CLR_PORTS; p++) begin
      clr_mask = clr_mask | NUM_ENTRIES'(onehot_mask(32'(clr_index[p*ENTRY_W +: ENTRY_W]),
                                                     NUM_ENTRIES, clr_val[p]));
    end
  end

  // Clear is applied last so it wins over a same-cycle set or grant.
  always_comb begin
    valid_d = (valid_q | set_mask | alloc_mask) & ~clr_mask;
    count_d = COUNT_W'(popcount(wide_mask_t'(valid_d)));
    full_d  = (count_d == COUNT_W'(NUM_ENTRIES));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign valid_bitvector = valid_q;
  assign occupied_count  = count_q;
  assign full            = full_q;
  assign empty           = empty_q;

`ifdef VALID_BITVECTOR_ALLOC_DBL_FREE_CHK_EN
  logic                   err_q, err_d;
  logic [ENTRY_W-1:0]     err_idx_q, err_idx_d;
  logic                   bad_any;
  logic [ENTRY_W-1:0]     bad_idx;
  logic [ENTRY_W-1:0]     port_idx;
  logic [NUM_ENTRIES-1:0] live;

  // A clear is legal if the slot is occupied now or becomes occupied this cycle.
  always_comb begin
    live     = valid_q | set_mask | alloc_mask;
    bad_any  = 1'b0;
    bad_idx  = '0;
    port_idx = '0;
    for (int p = NUM_CLR_PORTS - 1; p >= 0; p--) begin
      port_idx = clr_index[p*ENTRY_W +: ENTRY_W];
      if (clr_val[p] && (32'(port_idx) < NUM_ENTRIES) && !live[port_idx]) begin
        bad_any = 1'b1;
        bad_idx = port_idx;
      end
    end
    err_d     = err_q | bad_any;
    err_idx_d = (!err_q && bad_any) ? bad_idx : err_idx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign dbl_free_err   = err_q;
  assign dbl_free_index = err_idx_q;
`endif

endmodule

// File: tb/tb_valid_bitvector_alloc.sv
// Directed and model-checked bench for the valid-bitvector slot allocator.
module tb_valid_bitvector_alloc;

  localparam int N  = 64;
  localparam int EW = 6;
  localparam int NP = 2;
  localparam int CW = 7;

  logic           clk = 1'b0;
  logic           rst;
  logic           alloc_req_val;
  logic           alloc_req_rdy;
  logic [EW-1:0]  alloc_index;
  logic           set_val;
  logic [EW-1:0]  set_index;
  logic [NP-1:0]  clr_val;
  logic [NP*EW-1:0] clr_index;
  logic [N-1:0]   valid_bitvector;
  logic [CW-1:0]  occupied_count;
  logic           full;
  logic           empty;
`ifdef VALID_BITVECTOR_ALLOC_DBL_FREE_CHK_EN
  logic           dbl_free_err;
  logic [EW-1:0]  dbl_free_index;
`endif

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  always #5 clk = ~clk;

  valid_bitvector_alloc #(.NUM_ENTRIES(N), .NUM_CLR_PORTS(NP)) dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_req_val  (alloc_req_val),
    .alloc_req_rdy  (alloc_req_rdy),
    .alloc_index    (alloc_index),
    .set_val        (set_val),
    .set_index      (set_index),
    .clr_val        (clr_val),
    .clr_index      (clr_index),
    .valid_bitvector(valid_bitvector),
    .occupied_count (occupied_count),
    .full           (full),
    .empty          (empty)
`ifdef VALID_BITVECTOR_ALLOC_DBL_FREE_CHK_EN
    ,
    .dbl_free_err   (dbl_free_err),
    .dbl_free_index (dbl_free_index)
`endif
  );

  task automatic idle();
    alloc_req_val = 1'b0;
    set_val       = 1'b0;
    set_index     = '0;
    clr_val       = '0;
    clr_index     = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    checks++; if (valid_bitvector !== 64'h0) begin errors++; $display("FAIL reset_valid got %h exp %h", valid_bitvector, 64'h0); end
    checks++; if (occupied_count !== 7'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", occupied_count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (alloc_req_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b exp 1", alloc_req_rdy); end
    checks++; if (alloc_index !== 6'd0) begin errors++; $display("FAIL reset_index got %0d exp 0", alloc_index); end
`ifdef VALID_BITVECTOR_ALLOC_DBL_FREE_CHK_EN
    checks++; if (dbl_free_err !== 1'b0) begin errors++; $display("FAIL reset_dbl_err got %b exp 0", dbl_free_err); end
    checks++; if (dbl_free_index !== 6'd0) begin errors++; $display("FAIL reset_dbl_idx got %0d exp 0", dbl_free_index); end
`endif
  endtask

  task automatic test_alloc_seq();
    logic [EW-1:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back(EW'(i));
    alloc_req_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      e = exp_q.pop_front();
      checks++; if (alloc_req_rdy !== 1'b1) begin errors++; $display("FAIL seq_rdy got %b exp 1", alloc_req_rdy); end
      checks++; if (alloc_index !== e) begin errors++; $display("FAIL seq_index got %0d exp %0d", alloc_index, e); end
      cycle();
    end
    idle();
    #1;
    checks++; if (valid_bitvector !== 64'hF) begin errors++; $display("FAIL seq_valid got %h exp %h", valid_bitvector, 64'hF); end
    checks++; if (occupied_count !== 7'd4) begin errors++; $display("FAIL seq_count got %0d exp 4", occupied_count); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL seq_empty got %b exp 0", empty); end
  endtask

  task automatic test_full_clear();
    do_reset();
    alloc_req_val = 1'b1;
    for (int i = 0; i < N; i++) cycle();
    #1;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", full); end
    checks++; if (occupied_count !== 7'd64) begin errors++; $display("FAIL full_count got %0d exp 64", occupied_count); end
    checks++; if (valid_bitvector !== {64{1'b1}}) begin errors++; $display("FAIL full_valid got %h exp all ones", valid_bitvector); end
    clr_val   = 2'b01;
    clr_index = {6'd0, 6'd5};
    #1;
    checks++; if (alloc_req_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy_with_clr got %b exp 0", alloc_req_rdy); end
    cycle();
    clr_val = '0;
    #1;
    checks++; if (alloc_req_rdy !== 1'b1) begin errors++; $display("FAIL freed_rdy got %b exp 1", alloc_req_rdy); end
    checks++; if (alloc_index !== 6'd5) begin errors++; $display("FAIL freed_index got %0d exp 5", alloc_index); end
    checks++; if (occupied_count !== 7'd63) begin errors++; $display("FAIL freed_count got %0d exp 63", occupied_count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL freed_full got %b exp 0", full); end
    cycle();
    idle();
    #1;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL refill_full got %b exp 1", full); end
  endtask

  task automatic test_set_with_alloc();
    do_reset();
    alloc_req_val = 1'b1;
    cycle();
    cycle();
    idle();
    #1;
    checks++; if (valid_bitvector !== 64'h3) begin errors++; $display("FAIL pre_set_valid got %h exp %h", valid_bitvector, 64'h3); end
    alloc_req_val = 1'b1;
    set_val       = 1'b1;
    set_index     = 6'd2;
    #1;
    checks++; if (alloc_index !== 6'd3) begin errors++; $display("FAIL set_alloc_index got %0d exp 3", alloc_index); end
    cycle();
    idle();
    #1;
    checks++; if (valid_bitvector !== 64'hF) begin errors++; $display("FAIL set_alloc_valid got %h exp %h", valid_bitvector, 64'hF); end
    checks++; if (occupied_count !== 7'd4) begin errors++; $display("FAIL set_alloc_count got %0d exp 4", occupied_count); end
    set_val   = 1'b1;
    set_index = 6'd1;
    cycle();
    idle();
    #1;
    checks++; if (valid_bitvector !== 64'hF) begin errors++; $display("FAIL reset_bit_valid got %h exp %h", valid_bitvector, 64'hF); end
    checks++; if (occupied_count !== 7'd4) begin errors++; $display("FAIL reset_bit_count got %0d exp 4", occupied_count); end
  endtask

  task automatic test_clr_collision();
    // starts from valid = 0xF
    set_val   = 1'b1;
    set_index = 6'd7;
    cycle();
    idle();
    #1;
    checks++; if (valid_bitvector !== 64'h8F) begin errors++; $display("FAIL set7_valid got %h exp %h", valid_bitvector, 64'h8F); end
    set_val   = 1'b1;
    set_index = 6'd7;
    clr_val   = 2'b11;
    clr_index = {6'd7, 6'd7};
    cycle();
    idle();
    #1;
    checks++; if (valid_bitvector !== 64'hF) begin errors++; $display("FAIL dual_clr_valid got %h exp %h", valid_bitvector, 64'hF); end
    checks++; if (occupied_count !== 7'd4) begin errors++; $display("FAIL dual_clr_count got %0d exp 4", occupied_count); end
    set_val   = 1'b1;
    set_index = 6'd7;
    clr_val   = 2'b11;
    clr_index = {6'd7, 6'd7};
    cycle();
    idle();
    #1;
    checks++; if (valid_bitvector !== 64'hF) begin errors++; $display("FAIL clr_unset_valid got %h exp %h", valid_bitvector, 64'hF); end
    checks++; if (occupied_count !== 7'd4) begin errors++; $display("FAIL clr_unset_count got %0d exp 4", occupied_count); end
    alloc_req_val = 1'b1;
    clr_val       = 2'b10;
    clr_index     = {6'd4, 6'd0};
    #1;
    checks++; if (alloc_index !== 6'd4) begin errors++; $display("FAIL clr_grant_index got %0d exp 4", alloc_index); end
    cycle();
    idle();
    #1;
    checks++; if (valid_bitvector !== 64'hF) begin errors++; $display("FAIL clr_grant_valid got %h exp %h", valid_bitvector, 64'hF); end
  endtask

`ifdef VALID_BITVECTOR_ALLOC_DBL_FREE_CHK_EN
  task automatic test_dbl_free();
    do_reset();
    alloc_req_val = 1'b1;
    for (int i = 0; i < 9; i++) cycle();
    idle();
    clr_val   = 2'b11;
    clr_index = {6'd9, 6'd3};
    #1;
    checks++; if (dbl_free_err !== 1'b0) begin errors++; $display("FAIL dbl_err_early got %b exp 0", dbl_free_err); end
    cycle();
    idle();
    #1;
    checks++; if (dbl_free_err !== 1'b1) begin errors++; $display("FAIL dbl_err got %b exp 1", dbl_free_err); end
    checks++; if (dbl_free_index !== 6'd9) begin errors++; $display("FAIL dbl_idx got %0d exp 9", dbl_free_index); end
    checks++; if (valid_bitvector !== 64'h1F7) begin errors++; $display("FAIL dbl_valid got %h exp %h", valid_bitvector, 64'h1F7); end
    clr_val   = 2'b01;
    clr_index = {6'd0, 6'd12};
    cycle();
    idle();
    cycle();
    checks++; if (dbl_free_err !== 1'b1) begin errors++; $display("FAIL dbl_err_sticky got %b exp 1", dbl_free_err); end
    checks++; if (dbl_free_index !== 6'd9) begin errors++; $display("FAIL dbl_idx_kept got %0d exp 9", dbl_free_index); end
  endtask
`endif

  task automatic test_random();
    logic [N-1:0]  mv, set_m, alloc_m, clr_m, occ, nxt;
    logic          e_rdy;
    logic [EW-1:0] e_idx;
    logic          m_err;
    logic [EW-1:0] m_eidx;
    logic [EW-1:0] ci;
    logic          bad;
    logic [EW-1:0] bad_i;
    do_reset();
    mv     = '0;
    m_err  = 1'b0;
    m_eidx = '0;
    for (int c = 0; c < 10000; c++) begin
      rst           = (c == 5000);
      alloc_req_val = ($urandom_range(0, 9) < 7);
      set_val       = ($urandom_range(0, 9) < 2);
      set_index     = EW'($urandom_range(0, N - 1));
      clr_val[0]    = ($urandom_range(0, 9) < 3);
      clr_val[1]    = ($urandom_range(0, 9) < 3);
      clr_index     = {EW'($urandom_range(0, N - 1)), EW'($urandom_range(0, N - 1))};
      #1;
      set_m = set_val ? (64'd1 << set_index) : 64'd0;
      occ   = mv | set_m;
      e_rdy = ~(&occ);
      e_idx = '0;
      for (int i = N - 1; i >= 0; i--) if (!occ[i]) e_idx = EW'(i);
      checks++; if (valid_bitvector !== mv) begin errors++; $display("FAIL rnd_valid c=%0d got %h exp %h", c, valid_bitvector, mv); end
      checks++; if (occupied_count !== CW'($countones(mv))) begin errors++; $display("FAIL rnd_count c=%0d got %0d exp %0d", c, occupied_count, $countones(mv)); end
      checks++; if (full !== (&mv)) begin errors++; $display("FAIL rnd_full c=%0d got %b exp %b", c, full, &mv); end
      checks++; if (empty !== (mv == '0)) begin errors++; $display("FAIL rnd_empty c=%0d got %b exp %b", c, empty, mv == '0); end
      checks++; if (alloc_req_rdy !== e_rdy) begin errors++; $display("FAIL rnd_rdy c=%0d got %b exp %b", c, alloc_req_rdy, e_rdy); end
      checks++; if (alloc_index !== e_idx) begin errors++; $display("FAIL rnd_index c=%0d got %0d exp %0d", c, alloc_index, e_idx); end
`ifdef VALID_BITVECTOR_ALLOC_DBL_FREE_CHK_EN
      checks++; if (dbl_free_err !== m_err) begin errors++; $display("FAIL rnd_dbl_err c=%0d got %b exp %b", c, dbl_free_err, m_err); end
      checks++; if (dbl_free_index !== m_eidx) begin errors++; $display("FAIL rnd_dbl_idx c=%0d got %0d exp %0d", c, dbl_free_index, m_eidx); end
`endif
      alloc_m = (alloc_req_val && e_rdy) ? (64'd1 << e_idx) : 64'd0;
      clr_m   = '0;
      bad     = 1'b0;
      bad_i   = '0;
      for (int p = NP - 1; p >= 0; p--) begin
        ci = clr_index[p*EW +: EW];
        if (clr_val[p]) begin
          clr_m[ci] = 1'b1;
          if (!(mv[ci] | set_m[ci] | alloc_m[ci])) begin
            bad   = 1'b1;
            bad_i = ci;
          end
        end
      end
      nxt = (mv | set_m | alloc_m) & ~clr_m;
      if (rst) begin
        nxt    = '0;
        m_err  = 1'b0;
        m_eidx = '0;
      end else if (!m_err && bad) begin
        m_err  = 1'b1;
        m_eidx = bad_i;
      end
      cycle();
      mv = nxt;
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    test_reset();
    test_alloc_seq();
    test_full_clear();
    test_set_with_alloc();
    test_clr_collision();
`ifdef VALID_BITVECTOR_ALLOC_DBL_FREE_CHK_EN
    test_dbl_free();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
